// File: rtl/pacman_mover.sv
// Pac-Man movement controller: once per frame it reads the neighbour-wall flags for the
// current position, then turns and/or steps Pac-Man based on the latched keyboard request.
module pacman_mover #(
    parameter int TILE_SH   = 5,
    parameter int STEP      = 2,
    parameter int START_TX  = 1,
    parameter int START_TY  = 1,
    parameter int QUERY_LAT = 1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    output logic [9:0] query_x,
    output logic [9:0] query_y,
    input  logic       wall_up,
    input  logic       wall_down,
    input  logic       wall_left,
    input  logic       wall_right,
    output logic [9:0] pac_x,
    output logic [9:0] pac_y,
    output logic [1:0] dir,
    output logic       moving,
    output logic       busy,
    output logic       tick_drop
);

    localparam int TILE = 1 << TILE_SH;
    localparam int HALF = TILE / 2;
    localparam logic [9:0] START_X = 10'(START_TX * TILE + HALF);
    localparam logic [9:0] START_Y = 10'(START_TY * TILE + HALF);
    localparam logic [9:0] STEP_V  = 10'(STEP);
    localparam logic [TILE_SH-1:0] HALF_V = TILE_SH'(HALF);
    localparam logic [1:0] LAT_INIT = 2'(QUERY_LAT - 1);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DECIDE,
        S_MOVE
    } state_t;

    state_t     state_q;
    logic [9:0] pacX_q, pacY_q;
    logic [9:0] pacX_d, pacY_d;
    logic [1:0] dir_q, reqDir_q, nd_q;
    logic [1:0] nd_d;
    logic       moving_q, busy_q, tickDrop_q, blocked_q;
    logic       blocked_d;
    logic [1:0] waitCnt_q;
    logic [3:0] wr_q;
    logic       keyValid;
    logic [1:0] keyDir;
    logic       aligned;
    logic       isReverse;

    always_comb begin
        keyValid = 1'b1;
        keyDir   = DIR_RIGHT;
        case (keycode)
            8'h1A:   keyDir = DIR_UP;
            8'h16:   keyDir = DIR_DOWN;
            8'h04:   keyDir = DIR_LEFT;
            8'h07:   keyDir = DIR_RIGHT;
            default: keyValid = 1'b0;
        endcase
    end

    assign aligned   = (pacX_q[TILE_SH-1:0] == HALF_V) && (pacY_q[TILE_SH-1:0] == HALF_V);
    // Up/down and left/right differ only in the low bit of the direction code.
    assign isReverse = (reqDir_q == {dir_q[1], ~dir_q[0]});

    always_comb begin
        nd_d = dir_q;
        if (isReverse) begin
            nd_d = reqDir_q;
        end else if (aligned && !wr_q[reqDir_q]) begin
            nd_d = reqDir_q;
        end
        blocked_d = aligned && wr_q[nd_d];
    end

    always_comb begin
        pacX_d = pacX_q;
        pacY_d = pacY_q;
        if (!blocked_q) begin
            case (nd_q)
                DIR_UP:    pacY_d = pacY_q - STEP_V;
                DIR_DOWN:  pacY_d = pacY_q + STEP_V;
                DIR_LEFT:  pacX_d = pacX_q - STEP_V;
                default:   pacX_d = pacX_q + STEP_V;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            pacX_q     <= START_X;
            pacY_q     <= START_Y;
            dir_q      <= DIR_RIGHT;
            reqDir_q   <= DIR_RIGHT;
            nd_q       <= DIR_RIGHT;
            moving_q   <= 1'b0;
            busy_q     <= 1'b0;
            tickDrop_q <= 1'b0;
            blocked_q  <= 1'b0;
            waitCnt_q  <= 2'd0;
            wr_q       <= 4'd0;
        end else begin
            tickDrop_q <= frame_tick && (state_q != S_IDLE);
            if (keyValid) begin
                reqDir_q <= keyDir;
            end
            case (state_q)
                S_IDLE: begin
                    if (frame_tick) begin
                        state_q   <= S_WAIT;
                        busy_q    <= 1'b1;
                        waitCnt_q <= LAT_INIT;
                    end
                end
                S_WAIT: begin
                    if (waitCnt_q == 2'd0) begin
                        wr_q    <= {wall_right, wall_left, wall_down, wall_up};
                        state_q <= S_DECIDE;
                    end else begin
                        waitCnt_q <= waitCnt_q - 2'd1;
                    end
                end
                S_DECIDE: begin
                    nd_q      <= nd_d;
                    blocked_q <= blocked_d;
                    state_q   <= S_MOVE;
                end
                S_MOVE: begin
                    dir_q    <= nd_q;
                    pacX_q   <= pacX_d;
                    pacY_q   <= pacY_d;
                    moving_q <= !blocked_q;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign query_x   = pacX_q;
    assign query_y   = pacY_q;
    assign pac_x     = pacX_q;
    assign pac_y     = pacY_q;
    assign dir       = dir_q;
    assign moving    = moving_q;
    assign busy      = busy_q;
    assign tick_drop = tickDrop_q;

endmodule

// File: tb/tb_pacman_mover.sv
// Bench for pacman_mover: a tile-maze model answers the wall queries and a
// position/heading model predicts each frame's move.
module tb_pacman_mover;

    localparam int LAT  = 4;
    localparam int STEP = 2;

    logic       Clk, Reset_n, frame_tick;
    logic [7:0] keycode;
    logic [9:0] query_x, query_y, pac_x, pac_y;
    logic       wall_up, wall_down, wall_left, wall_right;
    logic [1:0] dir;
    logic       moving, busy, tick_drop;

    logic       rst3_n, tick3, wallZero;
    logic [9:0] q3x, q3y, pac3x, pac3y;
    logic [1:0] dir3;
    logic       mov3, busy3, drop3;

    logic [3:0] wallPipe;
    bit         overrideEn;
    logic [3:0] overrideWalls;
    string      maze [15];

    int total, bad;
    int mx, my, mdir, mreq;
    bit mmov;

    pacman_mover dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .keycode(keycode),
        .query_x(query_x), .query_y(query_y),
        .wall_up(wall_up), .wall_down(wall_down), .wall_left(wall_left), .wall_right(wall_right),
        .pac_x(pac_x), .pac_y(pac_y), .dir(dir), .moving(moving), .busy(busy), .tick_drop(tick_drop)
    );

    pacman_mover #(.QUERY_LAT(3)) dut3 (
        .Clk(Clk), .Reset_n(rst3_n), .frame_tick(tick3), .keycode(keycode),
        .query_x(q3x), .query_y(q3y),
        .wall_up(wallZero), .wall_down(wallZero), .wall_left(wallZero), .wall_right(wallZero),
        .pac_x(pac3x), .pac_y(pac3y), .dir(dir3), .moving(mov3), .busy(busy3), .tick_drop(drop3)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic bit isWall(input int tx, input int ty);
        string row;
        if (tx < 0 || tx >= 20 || ty < 0 || ty >= 15) return 1'b1;
        row = maze[ty];
        return row[tx] == "#";
    endfunction

    // Bit index matches the heading code: up, down, left, right.
    function automatic logic [3:0] lookupWalls(input int px, input int py);
        int tx, ty;
        logic [3:0] w;
        if (overrideEn) return overrideWalls;
        tx = px / 32;
        ty = py / 32;
        w[0] = isWall(tx, ty - 1);
        w[1] = isWall(tx, ty + 1);
        w[2] = isWall(tx - 1, ty);
        w[3] = isWall(tx + 1, ty);
        return w;
    endfunction

    always @(posedge Clk) wallPipe <= lookupWalls(int'(query_x), int'(query_y));
    assign wall_up    = wallPipe[0];
    assign wall_down  = wallPipe[1];
    assign wall_left  = wallPipe[2];
    assign wall_right = wallPipe[3];

    function automatic int keyToDir(input logic [7:0] k);
        case (k)
            8'h1A:   return 0;
            8'h16:   return 1;
            8'h04:   return 2;
            8'h07:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int opposite(input int d);
        case (d)
            0:       return 1;
            1:       return 0;
            2:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic void modelFrame();
        bit al;
        logic [3:0] w;
        int nd;
        bit blk;
        al = (mx % 32 == 16) && (my % 32 == 16);
        w  = lookupWalls(mx, my);
        if (mreq == opposite(mdir)) nd = mreq;
        else if (al && !w[mreq]) nd = mreq;
        else nd = mdir;
        blk  = al && w[nd];
        mdir = nd;
        mmov = !blk;
        if (!blk) begin
            case (nd)
                0:       my = my - STEP;
                1:       my = my + STEP;
                2:       mx = mx - STEP;
                default: mx = mx + STEP;
            endcase
        end
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] key);
        keycode = key;
        if (keyToDir(key) >= 0) mreq = keyToDir(key);
        cyc(1);
    endtask

    task automatic doReset();
        frame_tick = 1'b0;
        keycode    = 8'h00;
        Reset_n    = 1'b0;
        cyc(1);
        mx = 48; my = 48; mdir = 3; mreq = 3; mmov = 0;
        checkOutput("rst_pac_x", 32'(pac_x), 32'(mx));
        checkOutput("rst_pac_y", 32'(pac_y), 32'(my));
        checkOutput("rst_query_x", 32'(query_x), 32'd48);
        checkOutput("rst_dir", 32'(dir), 32'd3);
        checkOutput("rst_moving", 32'(moving), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_tick_drop", 32'(tick_drop), 32'd0);
        Reset_n = 1'b1;
    endtask

    // dropAt (1..LAT-1) raises a second tick in that busy cycle; 0 means none.
    task automatic runFrame(input int dropAt);
        int ox, oy, od;
        bit om, done;
        ox = mx; oy = my; od = mdir; om = mmov;
        modelFrame();
        frame_tick = 1'b1;
        cyc(1);
        for (int k = 1; k <= LAT; k++) begin
            done = (k == LAT);
            checkOutput("pac_x", 32'(pac_x), 32'(done ? mx : ox));
            checkOutput("pac_y", 32'(pac_y), 32'(done ? my : oy));
            checkOutput("query_y", 32'(query_y), 32'(done ? my : oy));
            checkOutput("dir", 32'(dir), 32'(done ? mdir : od));
            checkOutput("moving", 32'(moving), 32'(done ? mmov : om));
            checkOutput("busy", 32'(busy), 32'(!done));
            checkOutput("tick_drop", 32'(tick_drop), 32'(dropAt != 0 && k == dropAt + 1));
            frame_tick = (k == dropAt);
            cyc(1);
        end
        frame_tick = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] keys [6];
        keys = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h00, 8'h55};
        maze[0]  = "####################";
        maze[1]  = "#........##........#";
        maze[2]  = "#.##.###.##.###.##.#";
        maze[3]  = "#..................#";
        maze[4]  = "#.##.#.######.#.##.#";
        maze[5]  = "#....#...##...#....#";
        maze[6]  = "####.###.##.###.####";
        maze[7]  = "#..................#";
        maze[8]  = "#.##.#.######.#.##.#";
        maze[9]  = "#....#........#....#";
        maze[10] = "#.##.###.##.###.##.#";
        maze[11] = "#..#............#..#";
        maze[12] = "##.#.#.######.#.#.##";
        maze[13] = "#....#........#....#";
        maze[14] = "####################";
        total = 0; bad = 0;
        overrideEn = 1'b1; overrideWalls = 4'b0000;
        wallZero = 1'b0; rst3_n = 1'b0; tick3 = 1'b0;
        Reset_n = 1'b0; frame_tick = 1'b0; keycode = 8'h00;
        cyc(2);

        // Open floor: first frame steps right by STEP.
        doReset();
        applyStimulus(8'h00);
        runFrame(0);
        checkOutput("first_x", 32'(pac_x), 32'd50);
        checkOutput("first_moving", 32'(moving), 32'd1);

        // Request down at the start centre, open and then walled.
        doReset();
        applyStimulus(8'h16);
        runFrame(0);
        checkOutput("down_dir", 32'(dir), 32'd1);
        checkOutput("down_y", 32'(pac_y), 32'd50);
        overrideWalls = 4'b0010;
        doReset();
        applyStimulus(8'h16);
        runFrame(0);
        checkOutput("downblk_dir", 32'(dir), 32'd3);
        checkOutput("downblk_x", 32'(pac_x), 32'd50);

        // Walk to (80,48) and stop against a wall on the right.
        overrideWalls = 4'b0000;
        doReset();
        applyStimulus(8'h00);
        for (int i = 0; i < 16; i++) runFrame(0);
        overrideWalls = 4'b1000;
        cyc(2);
        for (int i = 0; i < 3; i++) runFrame(0);
        checkOutput("stop_x", 32'(pac_x), 32'd80);
        checkOutput("stop_moving", 32'(moving), 32'd0);

        // Reversal is immediate even off-centre.
        overrideWalls = 4'b0000;
        doReset();
        applyStimulus(8'h00);
        runFrame(0);
        applyStimulus(8'h04);
        runFrame(0);
        checkOutput("rev_dir", 32'(dir), 32'd2);
        checkOutput("rev_x", 32'(pac_x), 32'd48);

        // Perpendicular request waits for the next tile centre.
        doReset();
        applyStimulus(8'h00);
        runFrame(0);
        runFrame(0);
        applyStimulus(8'h1A);
        for (int i = 0; i < 15; i++) runFrame(0);
        checkOutput("turn_x", 32'(pac_x), 32'd80);
        checkOutput("turn_y", 32'(pac_y), 32'd46);
        checkOutput("turn_dir", 32'(dir), 32'd0);

        // Second tick two cycles after the first is dropped.
        doReset();
        applyStimulus(8'h00);
        runFrame(2);
        cyc(3);
        checkOutput("drop_x", 32'(pac_x), 32'd50);
        checkOutput("drop_busy", 32'(busy), 32'd0);

        // Reset in the middle of an update.
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        checkOutput("wait_busy", 32'(busy), 32'd1);
        Reset_n = 1'b0;
        cyc(1);
        checkOutput("midrst_x", 32'(pac_x), 32'd48);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_dir", 32'(dir), 32'd3);
        Reset_n = 1'b1;

        // Reset and tick together: the tick is lost.
        Reset_n = 1'b0;
        frame_tick = 1'b1;
        cyc(1);
        Reset_n = 1'b1;
        frame_tick = 1'b0;
        cyc(1);
        checkOutput("simul_busy", 32'(busy), 32'd0);
        checkOutput("simul_drop", 32'(tick_drop), 32'd0);
        mx = 48; my = 48; mdir = 3; mreq = 3; mmov = 0;

        // Three-cycle wall lookup: move lands six cycles after the tick.
        rst3_n = 1'b0;
        cyc(1);
        rst3_n = 1'b1;
        tick3 = 1'b1;
        cyc(1);
        tick3 = 1'b0;
        for (int k = 1; k < 6; k++) begin
            checkOutput("lat3_hold_x", 32'(pac3x), 32'd48);
            checkOutput("lat3_busy", 32'(busy3), 32'd1);
            cyc(1);
        end
        checkOutput("lat3_x", 32'(pac3x), 32'd50);
        checkOutput("lat3_qx", 32'(q3x), 32'd50);
        checkOutput("lat3_qy", 32'(q3y), 32'd48);
        checkOutput("lat3_y", 32'(pac3y), 32'd48);
        checkOutput("lat3_dir", 32'(dir3), 32'd3);
        checkOutput("lat3_moving", 32'(mov3), 32'd1);
        checkOutput("lat3_drop", 32'(drop3), 32'd0);
        checkOutput("lat3_idle", 32'(busy3), 32'd0);
        rst3_n = 1'b0;

        // Random walk through the real maze.
        overrideEn = 1'b0;
        doReset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) applyStimulus(keys[$urandom_range(0, 5)]);
            else applyStimulus(keycode);
            cyc($urandom_range(0, 2));
            runFrame($urandom_range(0, 1) == 1 ? int'($urandom_range(1, 3)) : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
